// File: rtl/perip_bus_arbiter_pkg.sv
// Shared encodings and types for the two-master peripheral bus arbiter.
package perip_bus_arbiter_pkg;

  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  localparam logic M0_ID = 1'b0;
  localparam logic M1_ID = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // The reserved size code 11 is issued to memory as a plain word access.
  function automatic logic [1:0] issue_mask(input logic [1:0] mask);
    return (mask == 2'b11) ? MASK_W : mask;
  endfunction

endpackage

// File: rtl/perip_bus_arbiter_if.sv
// One requester's single-beat bus: request side driven by the master, grant/read return by the arbiter.
interface perip_bus_arbiter_if;

  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [1:0]  mask;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, wen, addr, mask, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, mask, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/perip_rd_tag_pipe.sv
// Delays the {valid,id} tag of each issued access by the memory read latency
// so returning data can be steered to the master that asked for it.
module perip_rd_tag_pipe
  import perip_bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t [RD_LATENCY-1:0] pipe;

  generate
    if (RD_LATENCY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= push;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[RD_LATENCY-2:0], push};
      end
    end
  endgenerate

  assign tail = pipe[RD_LATENCY-1];

endmodule

// File: rtl/perip_bus_arbiter.sv
// Round-robin arbiter with bounded burst allowance sharing the single
// peripheral port between the CPU data port (m0) and a secondary master (m1).
module perip_bus_arbiter
  import perip_bus_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  perip_bus_arbiter_if.slave    m0,
  perip_bus_arbiter_if.slave    m1,
  output logic [31:0]           perip_addr,
  output logic                  perip_wen,
  output logic [1:0]            perip_mask,
  output logic [31:0]           perip_wdata,
  input  logic [31:0]           perip_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  arb_state_t       state, state_next;
  logic             idle_owner, idle_owner_next;
  logic [CNT_W-1:0] burst_cnt, burst_next;
  logic             last_owner;
  logic             winner;
  logic             any_req;
  logic             both_req;
  rd_tag_t          push_tag;
  rd_tag_t          tail_tag;

  // Ownership lives in the state while a master holds the bus; idle_owner
  // remembers it across idle cycles so the round-robin order survives gaps.
  assign last_owner = (state == ARB_OWN1) || ((state == ARB_IDLE) && idle_owner);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      idle_owner <= M0_ID;
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      idle_owner <= idle_owner_next;
      burst_cnt  <= burst_next;
    end
  end

  always_comb begin
    any_req         = m0.req | m1.req;
    both_req        = m0.req & m1.req;
    winner          = last_owner;
    state_next      = ARB_IDLE;
    idle_owner_next = last_owner;
    burst_next      = burst_cnt;

    if (both_req) begin
      winner = (burst_cnt < BURST_MAX) ? last_owner : ~last_owner;
      if (winner != last_owner)       burst_next = BURST_ONE;
      else if (burst_cnt != BURST_MAX) burst_next = burst_cnt + BURST_ONE;
    end else if (any_req) begin
      winner     = m1.req ? M1_ID : M0_ID;
      burst_next = BURST_ONE;
    end

    if (any_req) state_next = (winner == M1_ID) ? ARB_OWN1 : ARB_OWN0;
  end

  assign m0.gnt = any_req && (winner == M0_ID);
  assign m1.gnt = any_req && (winner == M1_ID);

  always_comb begin
    perip_addr  = '0;
    perip_wen   = 1'b0;
    perip_mask  = '0;
    perip_wdata = '0;
    if (any_req) begin
      if (winner == M1_ID) begin
        perip_addr  = m1.addr;
        perip_wen   = m1.wen;
        perip_mask  = issue_mask(m1.mask);
        perip_wdata = m1.wdata;
      end else begin
        perip_addr  = m0.addr;
        perip_wen   = m0.wen;
        perip_mask  = issue_mask(m0.mask);
        perip_wdata = m0.wdata;
      end
    end
  end

  assign push_tag.valid = any_req && !perip_wen;
  assign push_tag.id    = winner;

  perip_rd_tag_pipe #(.RD_LATENCY(RD_LATENCY)) u_tag_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push_tag),
    .tail (tail_tag)
  );

  assign m0.rvalid = tail_tag.valid && (tail_tag.id == M0_ID);
  assign m1.rvalid = tail_tag.valid && (tail_tag.id == M1_ID);
  assign m0.rdata  = perip_rdata;
  assign m1.rdata  = perip_rdata;

endmodule

// File: tb/tb_perip_bus_arbiter.sv
// Directed bench: dut_a runs with RD_LATENCY=1, dut_b with RD_LATENCY=3, both
// fed the same master requests; a small memory model answers each port.
module tb_perip_bus_arbiter;
  import perip_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  perip_bus_arbiter_if a0 ();
  perip_bus_arbiter_if a1 ();
  perip_bus_arbiter_if b0 ();
  perip_bus_arbiter_if b1 ();

  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        a_wen, b_wen;
  logic [1:0]  a_mask, b_mask;

  perip_bus_arbiter #(.RD_LATENCY(1), .MAX_BURST(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .m0(a0), .m1(a1),
    .perip_addr(a_addr), .perip_wen(a_wen), .perip_mask(a_mask),
    .perip_wdata(a_wdata), .perip_rdata(a_rdata)
  );

  perip_bus_arbiter #(.RD_LATENCY(3), .MAX_BURST(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .m0(b0), .m1(b1),
    .perip_addr(b_addr), .perip_wen(b_wen), .perip_mask(b_mask),
    .perip_wdata(b_wdata), .perip_rdata(b_rdata)
  );

  assign b0.req   = a0.req;
  assign b0.wen   = a0.wen;
  assign b0.addr  = a0.addr;
  assign b0.mask  = a0.mask;
  assign b0.wdata = a0.wdata;
  assign b1.req   = a1.req;
  assign b1.wen   = a1.wen;
  assign b1.addr  = a1.addr;
  assign b1.mask  = a1.mask;
  assign b1.wdata = a1.wdata;

  // Word memory shared by both ports; only dut_a's writes update it since both see identical traffic.
  logic [31:0] mem [256];
  logic [31:0] b_pipe [3];

  always @(posedge clk) begin
    if (a_wen) mem[a_addr[9:2]] <= a_wdata;
    a_rdata   <= ((a0.gnt || a1.gnt) && !a_wen) ? mem[a_addr[9:2]] : 32'h0;
    b_pipe[0] <= ((b0.gnt || b1.gnt) && !b_wen) ? mem[b_addr[9:2]] : 32'h0;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  assign b_rdata = b_pipe[2];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic wen,
                               input logic [31:0] addr, input logic [1:0] mask,
                               input logic [31:0] wdata);
    if (m == 0) begin
      a0.req = req; a0.wen = wen; a0.addr = addr; a0.mask = mask; a0.wdata = wdata;
    end else begin
      a1.req = req; a1.wen = wen; a1.addr = addr; a1.mask = mask; a1.wdata = wdata;
    end
  endtask

  task automatic idleBoth();
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    idleBoth();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    idleBoth();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_m0_gnt",    32'(a0.gnt),    32'd0);
    checkOutput("rst_m1_gnt",    32'(a1.gnt),    32'd0);
    checkOutput("rst_perip_wen", 32'(a_wen),     32'd0);
    checkOutput("rst_m0_rvalid", 32'(a0.rvalid), 32'd0);
    checkOutput("rst_b1_rvalid", 32'(b1.rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] lone M0 write then read");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h8000_0010, 2'b10, 32'hDEAD_BEEF);
    #1;
    checkOutput("wr_m0_gnt",      32'(a0.gnt), 32'd1);
    checkOutput("wr_m1_gnt",      32'(a1.gnt), 32'd0);
    checkOutput("wr_perip_wen",   32'(a_wen),  32'd1);
    checkOutput("wr_perip_addr",  a_addr,      32'h8000_0010);
    checkOutput("wr_perip_wdata", a_wdata,     32'hDEAD_BEEF);
    checkOutput("wr_perip_mask",  32'(a_mask), 32'd2);

    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h8000_0010, 2'b10, 32'h0);
    #1;
    checkOutput("rd_m0_gnt",     32'(a0.gnt), 32'd1);
    checkOutput("rd_perip_wen",  32'(a_wen),  32'd0);
    checkOutput("rd_perip_addr", a_addr,      32'h8000_0010);

    @(negedge clk);
    idleBoth();
    #1;
    checkOutput("rd_m0_rvalid",    32'(a0.rvalid), 32'd1);
    checkOutput("rd_m0_rdata",     a0.rdata,       32'hDEAD_BEEF);
    checkOutput("rd_m1_rvalid",    32'(a1.rvalid), 32'd0);
    checkOutput("idle_perip_addr", a_addr,         32'h0);
    checkOutput("idle_m0_gnt",     32'(a0.gnt),    32'd0);

    @(negedge clk);
    #1;
    checkOutput("rd_rvalid_once", 32'(a0.rvalid), 32'd0);

    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0040, 2'b11, 32'h1234_5678);
    #1;
    checkOutput("m11_m1_gnt",     32'(a1.gnt), 32'd1);
    checkOutput("m11_m0_gnt",     32'(a0.gnt), 32'd0);
    checkOutput("m11_perip_mask", 32'(a_mask), 32'd2);

    $display("[TB] alternating reads with RD_LATENCY=3");
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 2'b10, 32'h1111_0100);
    #1;
    checkOutput("pre_wr_b0_gnt", 32'(b0.gnt), 32'd1);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 2'b10, 32'h2222_0200);
    #1;
    checkOutput("pre_wr_b1_gnt", 32'(b1.gnt), 32'd1);

    for (int i = 0; i < 8; i++) begin
      logic exp0, exp1;
      @(negedge clk);
      if (i < 4) begin
        if (i % 2 == 0) begin
          applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 2'b10, 32'h0);
          applyStimulus(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
        end else begin
          applyStimulus(0, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
          applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 2'b10, 32'h0);
        end
      end else begin
        idleBoth();
      end
      #1;
      exp0 = (i == 3) || (i == 5);
      exp1 = (i == 4) || (i == 6);
      if (i < 4) checkOutput("alt_b1_gnt", 32'(b1.gnt), 32'(i % 2));
      checkOutput("alt_b0_rvalid", 32'(b0.rvalid), 32'(exp0));
      checkOutput("alt_b1_rvalid", 32'(b1.rvalid), 32'(exp1));
      if (exp0) checkOutput("alt_b0_rdata", b0.rdata, 32'h1111_0100);
      if (exp1) checkOutput("alt_b1_rdata", b1.rdata, 32'h2222_0200);
    end

    $display("[TB] reset with a read in flight");
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0100, 2'b10, 32'h0);
    #1;
    checkOutput("mid_b0_gnt", 32'(b0.gnt), 32'd1);
    @(negedge clk);
    idleBoth();
    #1;
    checkOutput("mid_a0_rvalid", 32'(a0.rvalid), 32'd1);
    checkOutput("mid_b0_rvalid", 32'(b0.rvalid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_a0_rvalid", 32'(a0.rvalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checkOutput("post_rst_b0_rvalid", 32'(b0.rvalid), 32'd0);
      checkOutput("post_rst_b1_rvalid", 32'(b1.rvalid), 32'd0);
      checkOutput("post_rst_a0_rvalid", 32'(a0.rvalid), 32'd0);
      checkOutput("post_rst_perip_wen", 32'(a_wen),     32'd0);
      checkOutput("post_rst_a0_gnt",    32'(a0.gnt),    32'd0);
    end

    $display("[TB] both masters requesting continuously");
    doReset();
    for (int i = 0; i < 12; i++) begin
      int expw;
      @(negedge clk);
      if (i == 0) begin
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_1000, 2'b10, 32'h0000_00A0);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_2000, 2'b10, 32'h0000_00B1);
      end
      #1;
      expw = (i / 4) % 2;
      checkOutput("burst_gnt0", 32'(a0.gnt), 32'(expw == 0));
      checkOutput("burst_gnt1", 32'(a1.gnt), 32'(expw == 1));
      checkOutput("burst_addr", a_addr, (expw == 1) ? 32'h0000_2000 : 32'h0000_1000);
    end

    $display("[TB] M1 drops request while M0 waits");
    doReset();
    @(negedge clk);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_2000, 2'b10, 32'h0000_00B1);
    #1;
    checkOutput("drop_c1_gnt1", 32'(a1.gnt), 32'd1);
    @(negedge clk);
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_1000, 2'b10, 32'h0000_00A0);
    #1;
    checkOutput("drop_c2_gnt1", 32'(a1.gnt), 32'd1);
    checkOutput("drop_c2_gnt0", 32'(a0.gnt), 32'd0);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 2'b00, 32'h0);
    #1;
    checkOutput("drop_c3_gnt0", 32'(a0.gnt), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) applyStimulus(1, 1'b1, 1'b1, 32'h0000_2000, 2'b10, 32'h0000_00B1);
      #1;
      checkOutput("drop_tail_gnt0", 32'(a0.gnt), 32'(i < 3));
      checkOutput("drop_tail_gnt1", 32'(a1.gnt), 32'(i == 3));
    end
    @(negedge clk);
    idleBoth();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
